// File: rtl/sys_axi_rd_slave_if.sv
// rtl/sys_axi_rd_slave_if.sv - AXI4 read-address channel interface
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

interface sys_axi_ar #(
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache,
           arprot, arqos, arregion, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache,
           arprot, arqos, arregion, arvalid,
    output arready
  );
endinterface

// File: rtl/sys_axi_rd_slave.sv
// rtl/sys_axi_rd_slave.sv - AXI4 read slave: one burst at a time, memory-backed R channel
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module sys_axi_rd_slave #(
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sys_axi_ar.slave              axi_ar,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BLOG  = $clog2(BYTES);
  localparam logic [1:0] AXI_FIXED = 2'b00;
  localparam logic [1:0] AXI_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [8:0]            issue_cnt_q;
  logic                  infl_q;
  logic                  infl_last_q;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_resp_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  ar_fire, accept_err, issue, push, pop, r_fire, burst_done;
  logic [DATA_WIDTH-1:0] infl_data;
  logic [1:0]            infl_resp;
  logic [ADDR_WIDTH-1:0] size_bytes, aligned, incr_addr, wrap_mask, next_addr;

  logic unused_ar;
  assign unused_ar = ^{axi_ar.arlock, axi_ar.arcache, axi_ar.arprot,
                       axi_ar.arqos, axi_ar.arregion};

  assign axi_ar.arready = (state_q == IDLE) && !rst_i;
  assign ar_fire        = axi_ar.arvalid && axi_ar.arready;

  assign accept_err = (axi_ar.arburst == 2'b11)
                   || (int'(axi_ar.arsize) > BLOG)
                   || ((axi_ar.arburst == AXI_WRAP)
                       && !(axi_ar.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Issue only while the word in flight plus buffered beats leave a free slot,
  // so returning memory data can always be captured.
  assign issue = (state_q == BURST)
              && (issue_cnt_q <= {1'b0, len_q})
              && ((count_q + {1'b0, infl_q}) < 2'd2);

  assign mem_req_o  = issue && !err_q;
  assign mem_addr_o = addr_q & ~ADDR_WIDTH'(BYTES - 1);

  assign infl_data = err_q ? '0 : mem_rdata_i;
  assign infl_resp = err_q ? 2'b10 : 2'b00;

  // Address of the following beat; unaligned start collapses onto the size grid.
  always_comb begin
    size_bytes = ADDR_WIDTH'(1) << size_q;
    aligned    = addr_q & ~(size_bytes - ADDR_WIDTH'(1));
    incr_addr  = aligned + size_bytes;
    wrap_mask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      AXI_FIXED: next_addr = addr_q;
      AXI_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:   next_addr = incr_addr;
    endcase
  end

  // The in-flight word bypasses the empty buffer so the first beat lands at T+2.
  always_comb begin
    rvalid = (count_q != 2'd0) || infl_q;
    rdata  = '0;
    rresp  = 2'b00;
    rlast  = 1'b0;
    if (count_q != 2'd0) begin
      rdata = buf_data_q[rd_ptr_q];
      rresp = buf_resp_q[rd_ptr_q];
      rlast = buf_last_q[rd_ptr_q];
    end else if (infl_q) begin
      rdata = infl_data;
      rresp = infl_resp;
      rlast = infl_last_q;
    end
  end

  assign rid        = id_q;
  assign r_fire     = rvalid && rready;
  assign burst_done = r_fire && rlast;
  assign pop        = r_fire && (count_q != 2'd0);
  assign push       = infl_q && !((count_q == 2'd0) && rready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_fire) state_d = BURST;
      BURST:   if (burst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire) begin
        id_q        <= axi_ar.arid;
        addr_q      <= axi_ar.araddr;
        len_q       <= axi_ar.arlen;
        size_q      <= axi_ar.arsize;
        burst_q     <= axi_ar.arburst;
        err_q       <= accept_err;
        issue_cnt_q <= '0;
      end else if (issue) begin
        addr_q      <= next_addr;
        issue_cnt_q <= issue_cnt_q + 9'd1;
      end
      infl_q      <= issue;
      infl_last_q <= (issue_cnt_q == {1'b0, len_q});
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= infl_data;
      buf_resp_q[wr_ptr_q] <= infl_resp;
      buf_last_q[wr_ptr_q] <= infl_last_q;
    end
  end
endmodule

// File: tb/tb_sys_axi_rd_slave.sv
// tb/tb_sys_axi_rd_slave.sv - directed self-checking bench for sys_axi_rd_slave
module tb_sys_axi_rd_slave;
  logic        clk;
  logic        rst_i;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_rdata_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] req_addr [$];
  int          req_cyc  [$];
  logic [63:0] bt_data  [$];
  logic [1:0]  bt_resp  [$];
  logic        bt_last  [$];
  logic [3:0]  bt_id    [$];
  int          bt_cyc   [$];

  sys_axi_ar #(.ID_WIDTH(4), .ADDR_WIDTH(32)) ar_if ();

  sys_axi_rd_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .axi_ar     (ar_if),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] memf(input logic [31:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= memf(mem_addr_o);
    else           mem_rdata_i <= 64'hBADB_AD00_5EED_0000;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    ar_if.arid    = id;
    ar_if.araddr  = a;
    ar_if.arlen   = len;
    ar_if.arsize  = size;
    ar_if.arburst = burst;
    ar_if.arvalid = 1'b1;
    check("arready_before_ar", {63'd0, ar_if.arready}, 64'd1);
    step();
    ar_if.arvalid = 1'b0;
  endtask

  task automatic collect(input int budget, input logic [3:0] pat);
    logic        done, prev_stall, pl;
    logic [63:0] pd;
    logic [1:0]  pr;
    logic [3:0]  pi;
    int          k;
    req_addr.delete(); req_cyc.delete();
    bt_data.delete(); bt_resp.delete(); bt_last.delete(); bt_id.delete(); bt_cyc.delete();
    done = 1'b0; prev_stall = 1'b0; pl = 1'b0; pd = '0; pr = '0; pi = '0;
    k = 1;
    while (!done && k <= budget) begin
      rready = pat[(k - 1) % 4];
      if (prev_stall) begin
        check("stall_rvalid", {63'd0, rvalid}, 64'd1);
        check("stall_rdata", rdata, pd);
        check("stall_rresp", {62'd0, rresp}, {62'd0, pr});
        check("stall_rlast", {63'd0, rlast}, {63'd0, pl});
        check("stall_rid", {60'd0, rid}, {60'd0, pi});
      end
      if (mem_req_o) begin
        req_addr.push_back(mem_addr_o);
        req_cyc.push_back(k);
      end
      if (rvalid && rready) begin
        bt_data.push_back(rdata); bt_resp.push_back(rresp); bt_last.push_back(rlast);
        bt_id.push_back(rid); bt_cyc.push_back(k);
        if (rlast) done = 1'b1;
      end
      prev_stall = rvalid && !rready;
      pd = rdata; pr = rresp; pl = rlast; pi = rid;
      step();
      k++;
    end
    check("burst_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [31:0] exp_addr [4];
    rst_i = 1'b1;
    rready = 1'b0;
    ar_if.arvalid = 1'b0; ar_if.arid = '0; ar_if.araddr = '0; ar_if.arlen = '0;
    ar_if.arsize = '0; ar_if.arburst = '0; ar_if.arlock = 1'b0; ar_if.arcache = '0;
    ar_if.arprot = '0; ar_if.arqos = '0; ar_if.arregion = '0;
    @(negedge clk);
    step();

    // reset state
    check("rst_arready", {63'd0, ar_if.arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_rresp", {62'd0, rresp}, 64'd0);
    check("rst_rid", {60'd0, rid}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst_i = 1'b0;
    step();
    check("post_rst_arready", {63'd0, ar_if.arready}, 64'd1);

    // INCR 0x1000 len 3 size 3: exact latency and throughput
    start_ar(4'd1, 32'h1000, 8'd3, 3'd3, 2'b01);
    check("incr_arready_busy", {63'd0, ar_if.arready}, 64'd0);
    collect(20, 4'b1111);
    check("incr_nreq", req_addr.size(), 4);
    check("incr_nbeat", bt_data.size(), 4);
    exp_addr = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    for (int i = 0; i < 4 && i < req_addr.size() && i < bt_data.size(); i++) begin
      check("incr_addr", req_addr[i], exp_addr[i]);
      check("incr_req_cyc", req_cyc[i], i + 1);
      check("incr_beat_cyc", bt_cyc[i], i + 2);
      check("incr_data", bt_data[i], memf(exp_addr[i]));
      check("incr_resp", {62'd0, bt_resp[i]}, 64'd0);
      check("incr_last", {63'd0, bt_last[i]}, (i == 3) ? 64'd1 : 64'd0);
      check("incr_rid", {60'd0, bt_id[i]}, 64'd1);
    end
    check("incr_arready_after", {63'd0, ar_if.arready}, 64'd1);

    // WRAP 0x1018 len 3 size 3
    start_ar(4'd2, 32'h1018, 8'd3, 3'd3, 2'b10);
    collect(20, 4'b1111);
    check("wrap_nreq", req_addr.size(), 4);
    exp_addr = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
    for (int i = 0; i < 4 && i < req_addr.size() && i < bt_data.size(); i++) begin
      check("wrap_addr", req_addr[i], exp_addr[i]);
      check("wrap_data", bt_data[i], memf(exp_addr[i]));
    end

    // INCR len 7 with rready 1,0,0,1
    start_ar(4'd3, 32'h2000, 8'd7, 3'd3, 2'b01);
    collect(60, 4'b1001);
    check("stall_nreq", req_addr.size(), 8);
    check("stall_nbeat", bt_data.size(), 8);
    for (int i = 0; i < 8 && i < bt_data.size(); i++) begin
      check("stall_data", bt_data[i], memf(32'h2000 + 32'(i * 8)));
      check("stall_last", {63'd0, bt_last[i]}, (i == 7) ? 64'd1 : 64'd0);
    end
    if (req_cyc.size() == 8) check("stall_req_paused", {63'd0, (req_cyc[7] - req_cyc[0]) > 7}, 64'd1);

    // error bursts: reserved burst type, oversize beat, illegal wrap length
    start_ar(4'd4, 32'h3000, 8'd2, 3'd3, 2'b11);
    collect(20, 4'b1111);
    check("err_rsv_nreq", req_addr.size(), 0);
    check("err_rsv_nbeat", bt_data.size(), 3);
    for (int i = 0; i < bt_data.size(); i++) begin
      check("err_rsv_resp", {62'd0, bt_resp[i]}, 64'd2);
      check("err_rsv_data", bt_data[i], 64'd0);
      check("err_rsv_last", {63'd0, bt_last[i]}, (i == 2) ? 64'd1 : 64'd0);
    end
    start_ar(4'd6, 32'h3000, 8'd1, 3'd4, 2'b01);
    collect(20, 4'b1111);
    check("err_size_nreq", req_addr.size(), 0);
    check("err_size_nbeat", bt_data.size(), 2);
    for (int i = 0; i < bt_data.size(); i++) begin
      check("err_size_resp", {62'd0, bt_resp[i]}, 64'd2);
      check("err_size_data", bt_data[i], 64'd0);
    end
    start_ar(4'd7, 32'h3000, 8'd2, 3'd3, 2'b10);
    collect(20, 4'b1111);
    check("err_wrap_nreq", req_addr.size(), 0);
    check("err_wrap_nbeat", bt_data.size(), 3);

    // reset during beat 2 of an 8-beat burst
    start_ar(4'd3, 32'h3000, 8'd7, 3'd3, 2'b01);
    rready = 1'b1;
    step(); step(); step();
    check("mid_beat2_data", rdata, memf(32'h3010));
    rst_i = 1'b1;
    step();
    check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("mid_rst_arready", {63'd0, ar_if.arready}, 64'd0);
    check("mid_rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("mid_rst_rdata", rdata, 64'd0);
    rst_i = 1'b0;
    step();
    check("mid_post_arready", {63'd0, ar_if.arready}, 64'd1);
    check("mid_post_rvalid", {63'd0, rvalid}, 64'd0);
    start_ar(4'd5, 32'h4000, 8'd1, 3'd3, 2'b01);
    collect(20, 4'b1111);
    check("mid_new_nbeat", bt_data.size(), 2);
    for (int i = 0; i < bt_data.size(); i++) begin
      check("mid_new_rid", {60'd0, bt_id[i]}, 64'd5);
      check("mid_new_data", bt_data[i], memf(32'h4000 + 32'(i * 8)));
    end

    // back-to-back single-beat bursts with arvalid held
    rready = 1'b1;
    ar_if.arid = 4'd1; ar_if.araddr = 32'h40; ar_if.arlen = 8'd0;
    ar_if.arsize = 3'd3; ar_if.arburst = 2'b01; ar_if.arvalid = 1'b1;
    step();
    check("b2b_busy1", {63'd0, ar_if.arready}, 64'd0);
    check("b2b_req1", {63'd0, mem_req_o}, 64'd1);
    ar_if.arid = 4'd2; ar_if.araddr = 32'h80;
    step();
    check("b2b_rvalid1", {63'd0, rvalid}, 64'd1);
    check("b2b_rlast1", {63'd0, rlast}, 64'd1);
    check("b2b_rid1", {60'd0, rid}, 64'd1);
    step();
    check("b2b_arready", {63'd0, ar_if.arready}, 64'd1);
    step();
    ar_if.arvalid = 1'b0;
    check("b2b_req2", {63'd0, mem_req_o}, 64'd1);
    check("b2b_addr2", {32'd0, mem_addr_o}, 64'h80);
    step();
    check("b2b_rid2", {60'd0, rid}, 64'd2);
    check("b2b_data2", rdata, memf(32'h80));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
